// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter sizing helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_p11.sv
// 1-bit full subtractor cell: a - b - c.
// Produces the difference bit and the outgoing borrow.
module p11 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first.
// One cell plus a borrow flop, WIDTH cycles per result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] pr_nxt;
    logic [CW-1:0]    count;
    logic             bf;
    logic             cd;
    logic             cb;
    logic             last;

    p11 u_cell (
        .a      (sa[0]),
        .b      (sb[0]),
        .c      (bf),
        .diff   (cd),
        .borrow (cb)
    );

    assign last   = (count == CW'(WIDTH - 1));
    assign pr_nxt = WIDTH'({cd, pr} >> 1);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state: accept in IDLE, leave RUN after the last bit.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Datapath: capture operands, shift one bit per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            pr         <= '0;
            bf         <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == IDLE && start) begin
            sa    <= a;
            sb    <= b;
            pr    <= '0;
            bf    <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            pr    <= pr_nxt;
            bf    <= cb;
            count <= count + CW'(1);
            if (last) begin
                diff       <= pr_nxt;
                borrow_out <= cb;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Vector table, random ops, corner sequences, WIDTH=3 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       busy3;
    logic       done3;
    logic [2:0] diff3;
    logic       borrow3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bw;
    } vec_t;

    vec_t vecs[4];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start3),
        .a          (a3),
        .b          (b3),
        .busy       (busy3),
        .done       (done3),
        .diff       (diff3),
        .borrow_out (borrow3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One full operation on the WIDTH=8 instance, checking
    // latency, result, the done pulse width and hold.
    task automatic run_op(input string name, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] ed,
                          input logic eb);
        int nb;
        bit seen;
        nb = 0;
        seen = 0;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        if (busy) nb++;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
        end
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " busy_cycles"}, nb, 8);
        chk({name, " diff"}, 32'(diff), 32'(ed));
        chk({name, " borrow"}, 32'(borrow_out), 32'(eb));
        @(negedge clk);
        chk({name, " done_pulse"}, 32'(done), 32'd0);
        chk({name, " diff_hold"}, 32'(diff), 32'(ed));
        chk({name, " borrow_hold"}, 32'(borrow_out), 32'(eb));
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int done_cyc[$];
        int extra_done;
        bit seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;

        vecs[0] = '{a: 8'd100, b: 8'd37, d: 8'd63,  bw: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd10, d: 8'hFB,  bw: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,  d: 8'hFF,  bw: 1'b1};
        vecs[3] = '{a: 8'hFF,  b: 8'hFF, d: 8'h00,  bw: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start3 = 1'b0;
        a3 = '0;
        b3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst diff", 32'(diff), 0);
        chk("rst borrow", 32'(borrow_out), 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].d, vecs[i].bw);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, ra - rb,
                   (ra < rb) ? 1'b1 : 1'b0);
        end

        // Start held high, operands churn every cycle.
        @(negedge clk);
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            if (c % 10 == 0) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            @(negedge clk);
            if (done) begin
                done_cyc.push_back(c);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    chk($sformatf("cont diff c%0d", c),
                        32'(diff), 32'(8'(ea - eb)));
                    chk($sformatf("cont borrow c%0d", c),
                        32'(borrow_out), 32'(ea < eb));
                end else begin
                    extra_done++;
                end
            end
            if (c == 39) start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
        end
        chk("cont done count", done_cyc.size(), 4);
        chk("cont extra done", extra_done, 0);
        for (int i = 1; i < done_cyc.size(); i++)
            chk($sformatf("cont spacing %0d", i),
                done_cyc[i] - done_cyc[i-1], 10);
        if (done_cyc.size() > 0)
            chk("cont first latency", done_cyc[0], 8);
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation.
        a = 8'd200;
        b = 8'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort busy before rst", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort diff", 32'(diff), 0);
        chk("abort borrow", 32'(borrow_out), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort no done", 32'(seen), 0);
        run_op("after abort", 8'd9, 8'd9, 8'd0, 1'b0);

        // Exhaustive sweep of the WIDTH=3 instance.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                @(negedge clk);
                a3 = 3'(x);
                b3 = 3'(y);
                start3 = 1'b1;
                @(posedge clk);
                @(negedge clk);
                start3 = 1'b0;
                a3 = 3'($urandom);
                b3 = 3'($urandom);
                seen = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (done3) begin
                        seen = 1;
                        break;
                    end
                end
                chk($sformatf("w3 done %0d-%0d", x, y), 32'(seen), 1);
                chk($sformatf("w3 diff %0d-%0d", x, y),
                    32'(diff3), 32'((x - y) & 7));
                chk($sformatf("w3 borrow %0d-%0d", x, y),
                    32'(borrow3), 32'(x < y));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
